// File: rtl/reception_logic.sv
// Receive-side opponent event decoder for the multiplayer UART link.
// Tracks match phase, filters repeated hits, counts hits and watches link liveness.
module reception_logic #(
  parameter int unsigned HIT_HOLDOFF = 1024,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned HIT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             multiplayer,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             start_game,
  input  logic             clear,
  output logic             opponent_ready,
  output logic             opponent_hit,
  output logic             opponent_game_over,
  output logic [HIT_W-1:0] hit_count,
  output logic             link_alive,
  output logic             bad_byte,
  output logic [1:0]       state
);

  localparam int unsigned HoldW = $clog2(HIT_HOLDOFF + 1);
  localparam int unsigned WdW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HIT_HOLDOFF - 1);
  localparam logic [WdW-1:0]   WdMax    = WdW'(TIMEOUT_CYC);
  localparam logic [HIT_W-1:0] HitMax   = '1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLobby   = 2'd1,
    StPlaying = 2'd2,
    StOver    = 2'd3
  } state_e;

  state_e           r_state;
  logic             r_ready;
  logic             r_hit;
  logic             r_over;
  logic [HIT_W-1:0] r_hits;
  logic             r_link;
  logic             r_bad;
  logic [HoldW-1:0] r_hold;
  logic [WdW-1:0]   r_wd;

  logic w_is_r;
  logic w_is_h;
  logic w_is_l;
  logic w_recog;
  logic w_bad;

  assign w_is_r  = rx_done && (rx_data == 8'h52);
  assign w_is_h  = rx_done && (rx_data == 8'h48);
  assign w_is_l  = rx_done && (rx_data == 8'h4C);
  assign w_recog = w_is_r || w_is_h || w_is_l;
  assign w_bad   = rx_done && !w_recog;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_ready <= 1'b0;
      r_hit   <= 1'b0;
      r_over  <= 1'b0;
      r_hits  <= '0;
      r_link  <= 1'b0;
      r_bad   <= 1'b0;
      r_hold  <= '0;
      r_wd    <= '0;
    end else begin
      r_hit <= 1'b0;
      r_bad <= 1'b0;
      if (r_hold != '0) r_hold <= r_hold - HoldW'(1);

      if (!multiplayer) begin
        r_state <= StIdle;
        r_ready <= 1'b0;
        r_over  <= 1'b0;
        r_hits  <= '0;
        r_link  <= 1'b0;
        r_hold  <= '0;
        r_wd    <= '0;
      end else begin
        // Watchdog is held idle in IDLE; a byte discarded by clear does not refresh it.
        if (r_state == StIdle) begin
          r_wd   <= '0;
          r_link <= 1'b0;
        end else if (w_recog && !clear) begin
          r_wd   <= '0;
          r_link <= 1'b1;
        end else if (r_wd != WdMax) begin
          r_wd <= r_wd + WdW'(1);
          if (r_wd + WdW'(1) == WdMax) r_link <= 1'b0;
        end

        if (clear) begin
          r_state <= StLobby;
          r_ready <= 1'b0;
          r_over  <= 1'b0;
          r_hits  <= '0;
          r_hold  <= '0;
        end else begin
          case (r_state)
            StIdle: r_state <= StLobby;
            StLobby: begin
              r_bad <= w_bad;
              if (w_is_r) r_ready <= 1'b1;
              if (start_game) r_state <= StPlaying;
            end
            StPlaying: begin
              r_bad <= w_bad;
              if (w_is_l) begin
                r_over  <= 1'b1;
                r_state <= StOver;
              end else if (w_is_h && (r_hold == '0)) begin
                r_hit  <= 1'b1;
                r_hold <= HoldLoad;
                if (r_hits != HitMax) r_hits <= r_hits + HIT_W'(1);
              end
            end
            StOver: r_bad <= w_bad;
            default: r_state <= StIdle;
          endcase
        end
      end
    end
  end

  assign opponent_ready     = r_ready;
  assign opponent_hit       = r_hit;
  assign opponent_game_over = r_over;
  assign hit_count          = r_hits;
  assign link_alive         = r_link;
  assign bad_byte           = r_bad;
  assign state              = r_state;

endmodule

// File: tb/tb_reception_logic.sv
// Directed plus random bench for reception_logic against an event-level reference model.
module tb_reception_logic;

  localparam int unsigned Hold = 1024;
  localparam int unsigned Tmo  = 100;
  localparam int unsigned Hw   = 2;
  localparam int unsigned Hmax = (1 << Hw) - 1;

  logic          clk;
  logic          rst;
  logic          multiplayer;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          start_game;
  logic          clear;
  logic          opponent_ready;
  logic          opponent_hit;
  logic          opponent_game_over;
  logic [Hw-1:0] hit_count;
  logic          link_alive;
  logic          bad_byte;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  reception_logic #(
    .HIT_HOLDOFF(Hold),
    .TIMEOUT_CYC(Tmo),
    .HIT_W      (Hw)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .multiplayer       (multiplayer),
    .rx_data           (rx_data),
    .rx_done           (rx_done),
    .start_game        (start_game),
    .clear             (clear),
    .opponent_ready    (opponent_ready),
    .opponent_hit      (opponent_hit),
    .opponent_game_over(opponent_game_over),
    .hit_count         (hit_count),
    .link_alive        (link_alive),
    .bad_byte          (bad_byte),
    .state             (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase plus event timestamps (edge numbers).
  int cyc = 0;
  int m_st, m_hits, m_last_hit, m_ref;
  bit m_ready, m_over, m_pulse, m_bad, m_have_hit, m_seen;

  function automatic void model_reset();
    m_st = 0; m_hits = 0; m_ready = 0; m_over = 0; m_pulse = 0; m_bad = 0;
    m_have_hit = 0; m_seen = 0; m_ref = cyc; m_last_hit = 0;
  endfunction

  function automatic void model_step();
    bit recog;
    int prev;
    recog = rx_done && (rx_data == 8'h52 || rx_data == 8'h48 || rx_data == 8'h4C);
    prev = m_st;
    m_pulse = 0;
    m_bad = 0;
    if (!multiplayer) begin
      model_reset();
      return;
    end
    if (prev == 0) begin
      m_ref = cyc; m_seen = 0;
    end else if (recog && !clear) begin
      m_ref = cyc; m_seen = 1;
    end
    if (clear) begin
      m_st = 1; m_ready = 0; m_over = 0; m_hits = 0; m_have_hit = 0;
    end else if (prev == 0) begin
      m_st = 1;
    end else begin
      m_bad = rx_done && !recog;
      if (prev == 1) begin
        if (rx_done && rx_data == 8'h52) m_ready = 1;
        if (start_game) m_st = 2;
      end else if (prev == 2) begin
        if (rx_done && rx_data == 8'h4C) begin
          m_over = 1; m_st = 3;
        end else if (rx_done && rx_data == 8'h48 &&
                     (!m_have_hit || cyc - m_last_hit >= int'(Hold))) begin
          m_pulse = 1;
          m_have_hit = 1;
          m_last_hit = cyc;
          if (m_hits < int'(Hmax)) m_hits++;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at t=%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare();
    check("state", 32'(state), 32'(m_st));
    check("opponent_ready", 32'(opponent_ready), 32'(m_ready));
    check("opponent_hit", 32'(opponent_hit), 32'(m_pulse));
    check("opponent_game_over", 32'(opponent_game_over), 32'(m_over));
    check("hit_count", 32'(hit_count), 32'(m_hits));
    check("link_alive", 32'(link_alive), 32'(m_seen && (cyc - m_ref) < int'(Tmo)));
    check("bad_byte", 32'(bad_byte), 32'(m_bad));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_step();
    else model_reset();
    #1;
    compare();
    rx_done = 1'b0;
    start_game = 1'b0;
    clear = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start();
    start_game = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; multiplayer = 1'b0; rx_data = 8'h00;
    rx_done = 1'b0; start_game = 1'b0; clear = 1'b0;
    model_reset();
    #1 compare();
    idle(2);
    rst = 1'b1;
    multiplayer = 1'b1;
    tick();
    // Ready byte in LOBBY
    send(8'h52);
    idle(2);
    // Hit filtering and saturation
    start();
    send(8'h48);
    idle(10);
    send(8'h48);
    idle(1100);
    send(8'h48);
    for (int i = 0; i < 3; i++) begin
      idle(1030);
      send(8'h48);
    end
    idle(2);
    // Game over, then return to lobby
    send(8'h4C);
    send(8'h48);
    idle(3);
    clear = 1'b1;
    tick();
    send(8'h41);
    idle(120);
    send(8'h52);
    idle(2);
    // Asynchronous reset mid-holdoff
    start();
    send(8'h48);
    idle(10);
    #2 rst = 1'b0;
    #1 model_reset();
    compare();
    idle(2);
    rst = 1'b1;
    tick();
    start();
    send(8'h48);
    idle(3);
    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      multiplayer = ($urandom_range(0, 399) != 0);
      clear = ($urandom_range(0, 199) == 0);
      start_game = ($urandom_range(0, 19) == 0);
      rx_done = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: rx_data = 8'h52;
        1: rx_data = 8'h48;
        2: rx_data = 8'h4C;
        default: rx_data = 8'($urandom_range(0, 255));
      endcase
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
